// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response bundle around the SRAM arbiter.
//   m0_*  MEM-stage data port (read/write): rd_en, wr_en, address, wdata -> rdata, ready
//   m1_*  IF-stage instruction port (read-only): rd_en, address -> rdata, ready
//   ct_*  SRAM controller side: rd_en, wr_en, address, wdata -> rdata, ready
// Modport slave is the arbiter's view; master is the surrounding system (stages + controller).
interface sram_arbiter_if;
    logic        m0_rd_en;
    logic        m0_wr_en;
    logic [31:0] m0_address;
    logic [31:0] m0_wdata;
    logic [31:0] m0_rdata;
    logic        m0_ready;

    logic        m1_rd_en;
    logic [31:0] m1_address;
    logic [31:0] m1_rdata;
    logic        m1_ready;

    logic        ct_rd_en;
    logic        ct_wr_en;
    logic [31:0] ct_address;
    logic [31:0] ct_wdata;
    logic [31:0] ct_rdata;
    logic        ct_ready;

    modport slave (
        input  m0_rd_en, m0_wr_en, m0_address, m0_wdata,
        output m0_rdata, m0_ready,
        input  m1_rd_en, m1_address,
        output m1_rdata, m1_ready,
        output ct_rd_en, ct_wr_en, ct_address, ct_wdata,
        input  ct_rdata, ct_ready
    );

    modport master (
        output m0_rd_en, m0_wr_en, m0_address, m0_wdata,
        input  m0_rdata, m0_ready,
        output m1_rd_en, m1_address,
        input  m1_rdata, m1_ready,
        input  ct_rd_en, ct_wr_en, ct_address, ct_wdata,
        output ct_rdata, ct_ready
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the MEM-stage data port (port 0, read/write)
// and the IF-stage instruction port (port 1, read-only). The winning request is latched into
// registered ct_* outputs and held until the controller completes; the granted port then sees a
// one-cycle ready together with the controller read data.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  sram_arbiter_if.slave (m0_*, m1_* requester side; ct_* controller side)
// Parameters:
//   FAIR     0 = port 0 always wins ties, 1 = round-robin on ties
//   MIN_LAT  initial BUSY cycles during which ct_ready is ignored (1..7)
module sram_arbiter #(
    parameter bit          FAIR    = 1'b0,
    parameter int unsigned MIN_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam logic [2:0] MinLat = 3'(MIN_LAT);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StRelease} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        ct_rd_en_q, ct_rd_en_d;
    logic        ct_wr_en_q, ct_wr_en_d;
    logic [31:0] ct_address_q, ct_address_d;
    logic [31:0] ct_wdata_q, ct_wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic req0, req1, busy, done, done0, done1, grant1;

    always_comb begin
        req0   = bus.m0_rd_en | bus.m0_wr_en;
        req1   = bus.m1_rd_en;
        busy   = (state_q == StBusy0) || (state_q == StBusy1);
        // ct_ready is only trusted once the controller has had MIN_LAT cycles of stable inputs
        done   = busy && bus.ct_ready && (cnt_q >= MinLat);
        done0  = done && (state_q == StBusy0);
        done1  = done && (state_q == StBusy1);
        // Port 1 wins when alone, or on a round-robin tie when port 0 was served last
        grant1 = req1 && (!req0 || (FAIR && !last_grant_q));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        ct_rd_en_d   = ct_rd_en_q;
        ct_wr_en_d   = ct_wr_en_q;
        ct_address_d = ct_address_q;
        ct_wdata_d   = ct_wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    cnt_d        = 3'd0;
                    last_grant_d = grant1;
                    if (grant1) begin
                        state_d      = StBusy1;
                        ct_rd_en_d   = 1'b1;
                        ct_wr_en_d   = 1'b0;
                        ct_address_d = bus.m1_address;
                        ct_wdata_d   = 32'd0;
                    end else begin
                        state_d      = StBusy0;
                        // Both enables high means a write
                        ct_rd_en_d   = bus.m0_rd_en & ~bus.m0_wr_en;
                        ct_wr_en_d   = bus.m0_wr_en;
                        ct_address_d = bus.m0_address;
                        ct_wdata_d   = bus.m0_wdata;
                    end
                end
            end
            StBusy0, StBusy1: begin
                if (done) begin
                    state_d    = StRelease;
                    ct_rd_en_d = 1'b0;
                    ct_wr_en_d = 1'b0;
                    if (done0 && ct_rd_en_q) begin
                        rdata0_d = bus.ct_rdata;
                    end
                    if (done1) begin
                        rdata1_d = bus.ct_rdata;
                    end
                end else begin
                    cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            ct_rd_en_q   <= 1'b0;
            ct_wr_en_q   <= 1'b0;
            ct_address_q <= 32'd0;
            ct_wdata_q   <= 32'd0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            ct_rd_en_q   <= ct_rd_en_d;
            ct_wr_en_q   <= ct_wr_en_d;
            ct_address_q <= ct_address_d;
            ct_wdata_q   <= ct_wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.ct_rd_en   = ct_rd_en_q;
    assign bus.ct_wr_en   = ct_wr_en_q;
    assign bus.ct_address = ct_address_q;
    assign bus.ct_wdata   = ct_wdata_q;

    // A port with no request never stalls; otherwise it is released only in its completion cycle
    assign bus.m0_ready = !req0 || done0;
    assign bus.m1_ready = !req1 || done1;
    assign bus.m0_rdata = done0 ? bus.ct_rdata : rdata0_q;
    assign bus.m1_rdata = done1 ? bus.ct_rdata : rdata1_q;

endmodule
